// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the RV32 integer register file
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - combinational read mux with x0 zeroing; write forwarding under REG_FILE_BYPASS_EN
module reg_file_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [DATA_W-1:0]                  data
);

`ifdef REG_FILE_BYPASS_EN
    // wr_en is already qualified with reset and the x0 check by the top
    always_comb begin
        data = regs[addr];
        if (wr_en && (addr == wr_addr)) begin
            data = wr_data;
        end
        if (addr == '0) begin
            data = '0;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 RV32 register file, two read ports, one write port; option REG_FILE_BYPASS_EN
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              rd_we,
    output logic [DATA_W-1:0] regOut1,
    output logic [DATA_W-1:0] regOut2
);
    import reg_file_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]            mem [1:NREGS-1];
    logic [NREGS-1:0][DATA_W-1:0] regs_flat;
    logic                         wr_en;

    assign wr_en = rst && rd_we && (writeReg != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[writeReg] <= writeData;
        end
    end

    // x0 has no storage; slot 0 of the flat view is tied to zero
    always_comb begin
        regs_flat[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            regs_flat[i] = mem[i];
        end
    end

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_read_port1 (
        .regs    (regs_flat),
        .addr    (readReg1),
        .wr_en   (wr_en),
        .wr_addr (writeReg),
        .wr_data (writeData),
        .data    (regOut1)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_read_port2 (
        .regs    (regs_flat),
        .addr    (readReg2),
        .wr_en   (wr_en),
        .wr_addr (writeReg),
        .wr_data (writeData),
        .data    (regOut2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (model + directed vectors, REG_FILE_BYPASS_EN aware)
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic        rd_we;
    logic [31:0] regOut1, regOut2;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [0:31];
    bit          model_valid = 1'b0;

    reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .rd_we     (rd_we),
        .regOut1   (regOut1),
        .regOut2   (regOut2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
            model_valid <= 1'b1;
        end else if (rd_we && writeReg != 5'd0) begin
            model[writeReg] <= writeData;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (rst && rd_we && writeReg != 5'd0 && a == writeReg) return writeData;
`endif
        return model[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_port1", regOut1, model_read(readReg1));
            check("model_port2", regOut2, model_read(readReg2));
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; rd_we = 1'b0; writeReg = 5'd0; writeData = 32'h0;
        readReg1 = 5'd0; readReg2 = 5'd0;
        edge_step();
        rst = 1'b1;

        for (int a = 1; a < 32; a++) begin
            readReg1 = 5'(a);
            readReg2 = 5'(32 - a);
            #1;
            check("reset_p1", regOut1, 32'h0);
            check("reset_p2", regOut2, 32'h0);
        end

        writeReg = 5'd5; writeData = 32'hA5A5A5A5; rd_we = 1'b1; readReg1 = 5'd5;
        edge_step();
        rd_we = 1'b0;
        #1 check("write_x5", regOut1, 32'hA5A5A5A5);

        writeReg = 5'd0; writeData = 32'hFFFFFFFF; rd_we = 1'b1; readReg1 = 5'd0;
        #1 check("x0_same_cycle", regOut1, 32'h0);
        edge_step();
        rd_we = 1'b0;
        #1 check("x0_after_write", regOut1, 32'h0);

        writeReg = 5'd10; writeData = 32'h12345678; rd_we = 1'b1;
        edge_step();
        rd_we = 1'b0; readReg1 = 5'd10; readReg2 = 5'd5;
        #1;
        check("x10_port1", regOut1, 32'h12345678);
        check("x5_port2", regOut2, 32'hA5A5A5A5);

        writeReg = 5'd31; writeData = 32'h80000001; rd_we = 1'b1;
        edge_step();
        rd_we = 1'b0; readReg2 = 5'd31; readReg1 = 5'd31;
        #1;
        check("x31_port2", regOut2, 32'h80000001);
        check("x31_port1", regOut1, 32'h80000001);

        writeReg = 5'd7; writeData = 32'hDEADBEEF; rd_we = 1'b0;
        edge_step();
        readReg1 = 5'd7;
        #1 check("no_we_x7", regOut1, 32'h0);

        rst = 1'b0; rd_we = 1'b1; writeReg = 5'd5; writeData = 32'h11111111;
        edge_step();
        rst = 1'b1; rd_we = 1'b0; readReg1 = 5'd5; readReg2 = 5'd10;
        #1;
        check("reset_wins_x5", regOut1, 32'h0);
        check("reset_clears_x10", regOut2, 32'h0);

        writeReg = 5'd3; writeData = 32'hCAFEF00D; rd_we = 1'b1; readReg1 = 5'd3; readReg2 = 5'd4;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("same_cycle_x3", regOut1, 32'hCAFEF00D);
`else
        check("same_cycle_x3", regOut1, 32'h0);
`endif
        check("same_cycle_other", regOut2, 32'h0);
        edge_step();
        rd_we = 1'b0;
        #1 check("after_edge_x3", regOut1, 32'hCAFEF00D);

        repeat (2) edge_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
